// File: rtl/mdu_hilo_ctrl_if.sv
// Bundle of signals between the ID/EXE stage and the multiply/divide sequencer.
// Carries the operation request, the forwarded operands and flush, plus the
// stall request, completion pulse and architectural HI/LO values.
interface mdu_hilo_ctrl_if;
  logic [2:0]  EXE_MDOp;
  logic [31:0] EXE_BusA;
  logic [31:0] EXE_BusB;
  logic        MD_Flush;
  logic        MD_Busy;
  logic        MD_Done;
  logic [31:0] HI;
  logic [31:0] LO;

  // Pipeline side: issues operations and observes HI/LO and the stall request.
  modport master (
    output EXE_MDOp, EXE_BusA, EXE_BusB, MD_Flush,
    input  MD_Busy, MD_Done, HI, LO
  );

  // Sequencer side.
  modport slave (
    input  EXE_MDOp, EXE_BusA, EXE_BusB, MD_Flush,
    output MD_Busy, MD_Done, HI, LO
  );
endinterface

// File: rtl/mdu_hilo_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers.
// Latency: multiply MULT_CYCLES total, divide DIV_ITER+3 total; MTHI/MTLO write in one cycle.
// Backpressure: MD_Busy stalls the front end while an operation runs; MD_Flush aborts it.
module mdu_hilo_ctrl #(
  parameter int MULT_CYCLES = 3,
  parameter int DIV_ITER    = 32
) (
  input  logic          clk,
  input  logic          rst,
  mdu_hilo_ctrl_if.slave md
);

  localparam int CW = 6;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_a;       // multiplicand
  logic [31:0]   r_b;       // multiplier, or divisor magnitude
  logic [31:0]   r_quo;     // dividend magnitude shifting out, quotient shifting in
  logic [31:0]   r_rem;     // partial remainder
  logic          r_signed;  // multiply operands are two's complement
  logic          r_is_div;
  logic          r_qneg;
  logic          r_rneg;

  logic          w_busy;
  logic          w_done;
  logic          w_start_mul;
  logic          w_start_div;
  logic          w_mthi;
  logic          w_mtlo;
  logic          w_wr_hilo;

  logic          w_op_mul;
  logic          w_op_div;
  logic          w_op_signed;
  logic          w_b_zero;
  logic [31:0]   w_a_abs;
  logic [31:0]   w_b_abs;
  logic [63:0]   w_ax;
  logic [63:0]   w_bx;
  logic [63:0]   w_prod;
  logic [32:0]   w_rem_sh;
  logic [32:0]   w_diff;

  assign w_op_mul    = (md.EXE_MDOp == OP_MULT) || (md.EXE_MDOp == OP_MULTU);
  assign w_op_div    = (md.EXE_MDOp == OP_DIV)  || (md.EXE_MDOp == OP_DIVU);
  assign w_op_signed = (md.EXE_MDOp == OP_MULT) || (md.EXE_MDOp == OP_DIV);
  assign w_b_zero    = (md.EXE_BusB == 32'd0);

  // Divide works on magnitudes; signs are reapplied in FIX.
  assign w_a_abs = (w_op_signed && md.EXE_BusA[31]) ? (32'd0 - md.EXE_BusA) : md.EXE_BusA;
  assign w_b_abs = (w_op_signed && md.EXE_BusB[31]) ? (32'd0 - md.EXE_BusB) : md.EXE_BusB;

  // Sign-extending (MULT) or zero-extending (MULTU) to 64 bits makes the
  // truncated 64-bit product correct for both flavours. The operands are
  // registered, so the multiplier has the whole MUL window to settle.
  assign w_ax   = {{32{r_signed & r_a[31]}}, r_a};
  assign w_bx   = {{32{r_signed & r_b[31]}}, r_b};
  assign w_prod = w_ax * w_bx;

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
  assign w_rem_sh = {r_rem, r_quo[31]};
  assign w_diff   = w_rem_sh - {1'b0, r_b};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, stall request and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_start_mul = 1'b0;
    w_start_div = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    w_wr_hilo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!md.MD_Flush) begin
          if (w_op_mul) begin
            w_start_mul = 1'b1;
            w_busy      = 1'b1;
            // With only two cycles of occupancy there is no waiting cycle.
            w_state_nxt = (MULT_CYCLES <= 2) ? S_DONE : S_MUL;
          end else if (w_op_div && !w_b_zero) begin
            w_start_div = 1'b1;
            w_busy      = 1'b1;
            w_state_nxt = S_DIV;
          end else if (md.EXE_MDOp == OP_MTHI) begin
            w_mthi = 1'b1;
          end else if (md.EXE_MDOp == OP_MTLO) begin
            w_mtlo = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (md.MD_Flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_busy = 1'b1;
          // The counter reaches zero on the edge that enters DONE.
          if (r_cnt <= CW'(1)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DIV: begin
        if (md.MD_Flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_busy = 1'b1;
          if (r_cnt == '0) begin
            w_state_nxt = S_FIX;
          end
        end
      end
      S_FIX: begin
        if (md.MD_Flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_busy      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        if (!md.MD_Flush) begin
          w_done    = 1'b1;
          w_wr_hilo = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture, iteration, sign fixup and HI/LO update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_signed <= 1'b0;
      r_is_div <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_mul) begin
            r_a      <= md.EXE_BusA;
            r_b      <= md.EXE_BusB;
            r_signed <= (md.EXE_MDOp == OP_MULT);
            r_is_div <= 1'b0;
            r_cnt    <= CW'(MULT_CYCLES - 2);
          end else if (w_start_div) begin
            r_quo    <= w_a_abs;
            r_b      <= w_b_abs;
            r_rem    <= '0;
            r_qneg   <= w_op_signed & (md.EXE_BusA[31] ^ md.EXE_BusB[31]);
            r_rneg   <= w_op_signed & md.EXE_BusA[31];
            r_is_div <= 1'b1;
            r_cnt    <= CW'(DIV_ITER - 1);
          end else if (w_mthi) begin
            r_hi <= md.EXE_BusA;
          end else if (w_mtlo) begin
            r_lo <= md.EXE_BusA;
          end
        end
        S_MUL: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DIV: begin
          r_rem <= w_diff[32] ? w_rem_sh[31:0] : w_diff[31:0];
          r_quo <= {r_quo[30:0], ~w_diff[32]};
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_FIX: begin
          if (r_qneg) begin
            r_quo <= 32'd0 - r_quo;
          end
          if (r_rneg) begin
            r_rem <= 32'd0 - r_rem;
          end
        end
        S_DONE: begin
          if (w_wr_hilo) begin
            r_hi <= r_is_div ? r_rem : w_prod[63:32];
            r_lo <= r_is_div ? r_quo : w_prod[31:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Stall is suppressed while reset is held even if an op is presented.
  assign md.MD_Busy = w_busy & rst;
  assign md.MD_Done = w_done;
  assign md.HI      = r_hi;
  assign md.LO      = r_lo;

endmodule

// File: doc/mdu_hilo_ctrl.md
Name: mdu_hilo_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers.
- Sits in EXE. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the ID/EXE stage register.
- While an operation runs, asserts a stall request to the hazard logic. The hazard logic then deasserts IF_PCWr/IF_IDWr and holds ID/EXE.
- Aborts cleanly when an older instruction's exception flushes EXE.

Parameters:
- MULT_CYCLES, 3, total cycles a multiply occupies EXE, including the completion cycle (min 2, max 8).
- DIV_ITER, 32, restoring-division iterations (fixed at 32 for 32-bit operands; kept as a parameter for bench shortening only).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- EXE_MDOp  in  3  000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NONE
- EXE_BusA  in  32  forwarded rs operand
- EXE_BusB  in  32  forwarded rt operand
- MD_Flush  in  1  kill current EXE instruction (exception/ERET in MEM)
- MD_Busy  out  1  stall request, combinational
- MD_Done  out  1  one-cycle pulse when HI/LO are written by MULT/DIV
- HI  out  32  architectural HI
- LO  out  32  architectural LO

Behaviour:
- Reset (rst=0, async): state=IDLE, HI=0, LO=0, MD_Done=0, counter=0, internal operand/partial registers=0. MD_Busy=0 during reset.

States:
- IDLE: waiting for an operation.
- MUL: multiply in progress.
- DIV: divide iterating.
- FIX: divide sign-fixup.
- DONE: completion cycle.

IDLE:
- EXE_MDOp=MULT/MULTU and !MD_Flush: latch operands, counter=MULT_CYCLES-2, go MUL. MD_Busy=1 this cycle.
- EXE_MDOp=DIV/DIVU and !MD_Flush, BusB!=0: latch |A|, |B| (signed) or raw (unsigned), record quotient sign (A[31]^B[31]) and remainder sign (A[31]) for DIV; counter=DIV_ITER-1, go DIV. MD_Busy=1.
- DIV/DIVU with BusB==0: HI/LO unchanged, no stall, stay IDLE, MD_Done=0.
- MTHI/MTLO and !MD_Flush: HI or LO <= BusA at clock edge, no stall.
- MD_Flush=1: no action for any op.

MUL:
- MD_Busy=1.
- Product is the 64-bit signed (MULT) or unsigned (MULTU) A*B; implementation may register/pipeline the product across MUL cycles.
- counter decrements each cycle; at counter==0 go DONE.

DIV:
- MD_Busy=1. One restoring step per cycle: shift {rem,quo} left 1, trial subtract divisor, set quotient bit if non-negative.
- At counter==0 go FIX.

FIX:
- MD_Busy=1.
- DIV: negate quotient if quotient sign=1; negate remainder if remainder sign=1.
- Go DONE.

DONE:
- MD_Busy=0, MD_Done=1.
- HI<=result_hi (product[63:32] / remainder), LO<=result_lo (product[31:0] / quotient) at this edge.
- Go IDLE. EXE_MDOp is ignored this cycle: the same instruction advances to MEM.

Latency (cycles with MD_Busy=1, including the start cycle):
- MULT: MULT_CYCLES-1, then DONE. Total occupancy MULT_CYCLES.
- DIV: 1 (start) + DIV_ITER + 1 (FIX) = 34 busy cycles, plus DONE = 35 total.

Flush:
- MD_Flush=1 in any non-IDLE state: next state IDLE, HI/LO untouched, MD_Done=0, MD_Busy=0 combinationally in that cycle.
- MD_Flush in DONE suppresses the HI/LO write.

Other rules:
- Reset mid-operation: immediate return to reset values; no partial write.
- Signed edge case: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no exception).
- MD_Busy is a pure function of state, EXE_MDOp, BusB==0 and MD_Flush; it must not depend on HI/LO.
- HI/LO outputs are registered. MFHI/MFLO in EXE read them directly: the producer has always completed DONE before a dependent instruction reaches EXE.

Test Plan:
- Reset held low mid-DIV (cycle 10), release: HI=LO=0, MD_Busy=0, state IDLE, no MD_Done.
- MULT A=0xFFFFFFFE (-2), B=0x00000003: MD_Busy high 2 cycles, MD_Done pulse on the 3rd, HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands: HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=0x00000002: 34 busy cycles, MD_Done on cycle 35, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7: LO=14, HI=2.
- DIV with B=0 after HI=0x11, LO=0x22: MD_Busy never asserts, MD_Done=0, HI/LO unchanged.
- DIVU started, MD_Flush asserted in iteration 20: MD_Busy drops that cycle, state IDLE next, HI/LO unchanged. A following MTLO 0x5 writes LO=5 with no stall.
- MULT in DONE with MD_Flush=1: no write. Back-to-back MULTU then MTHI 0xABCD: MTHI accepted the cycle after DONE, HI=0xABCD, LO=MULTU product low word.
